// File: rtl/instr_imm_stage.sv
// instr_imm_stage: two-entry registered decode buffer that splits RV64I fields and builds the raw 32-bit immediate.
// Optional opcode legality flag enabled by defining IMMGEN_ILLEGAL_CHECK_EN.
`default_nettype none

module instr_imm_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        illegal
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] imm_q   [DEPTH];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [31:0] imm_d;
  logic        push;
  logic        pop;

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    imm_d = 32'd0;
    case (instr_in[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
        imm_d = {{20{instr_in[31]}}, instr_in[31:20]};
      OP_STORE:
        imm_d = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      OP_BRANCH:
        imm_d = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_d = {instr_in[31:12], 12'd0};
      OP_JAL:
        imm_d = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      default:
        imm_d = 32'd0;
    endcase
  end

  // Flush clears storage as well so the empty stage presents the same values as after reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'd0;
        imm_q[i]   <= 32'd0;
      end
    end else begin
      if (push) begin
        instr_q[tail] <= instr_in;
        imm_q[tail]   <= imm_d;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMMGEN_ILLEGAL_CHECK_EN
  logic known_d;
  logic ill_q [DEPTH];

  always_comb begin
    known_d = 1'b0;
    case (instr_in[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32:
        known_d = 1'b1;
      default:
        known_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ill_q[i] <= 1'b0;
      end
    end else if (push) begin
      ill_q[tail] <= ~known_d;
    end
  end

  assign illegal = ill_q[head];
`else
  assign illegal = 1'b0;
`endif

  assign instr_out = instr_q[head];
  assign imm       = imm_q[head];
  assign opcode    = instr_out[6:0];
  assign rd        = instr_out[11:7];
  assign funct3    = instr_out[14:12];
  assign rs1       = instr_out[19:15];
  assign rs2       = instr_out[24:20];
  assign funct7    = instr_out[31:25];

endmodule

`default_nettype wire

// File: tb/tb_instr_imm_stage.sv
// tb_instr_imm_stage: scoreboard bench for instr_imm_stage with directed instruction vectors.
`default_nettype none

module tb_instr_imm_stage;

`ifdef IMMGEN_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, illegal;
  logic [31:0] instr_in, instr_out, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  instr_imm_stage #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head against the scoreboard whenever the DUT presents it.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("instr_out", instr_out, exp_q[0].instr);
        chk("opcode", 32'(opcode), 32'(exp_q[0].instr[6:0]));
        chk("rd", 32'(rd), 32'(exp_q[0].instr[11:7]));
        chk("funct3", 32'(funct3), 32'(exp_q[0].instr[14:12]));
        chk("rs1", 32'(rs1), 32'(exp_q[0].instr[19:15]));
        chk("rs2", 32'(rs2), 32'(exp_q[0].instr[24:20]));
        chk("funct7", 32'(funct7), 32'(exp_q[0].instr[31:25]));
        chk("imm", imm, exp_q[0].imm);
        chk("illegal", 32'(illegal), 32'(exp_q[0].ill & CHECK_EN));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [31:0] ins, input logic [31:0] im, input logic ill);
    bit done = 0;
    in_valid = 1'b1;
    instr_in = ins;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{ins, im, ill});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("push_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_empty(input string name);
    @(negedge clk);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_imm"}, imm, 32'd0);
    chk({name, "_instr_out"}, instr_out, 32'd0);
    chk({name, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic drain(input string name);
    bit done = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!out_valid) done = 1;
    end
    chk({name, "_drained"}, 32'(out_valid), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    instr_in = 32'hFFF00093;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    check_empty("reset");
    @(posedge clk); #1;

    // Single addi, then the stage must go empty again.
    push(32'hFFF00093, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    chk("addi_opcode", 32'(opcode), 32'h13);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("addi_gone", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Back-to-back across the immediate formats.
    push(32'hFE112E23, 32'hFFFFFFFC, 1'b0);
    push(32'hFE000CE3, 32'hFFFFFFF8, 1'b0);
    push(32'h123452B7, 32'h12345000, 1'b0);
    push(32'h001000EF, 32'h00000800, 1'b0);
    push(32'h002081B3, 32'h00000000, 1'b0);
    push(32'h7FF0A103, 32'h000007FF, 1'b0);
    push(32'hFFFFF517, 32'hFFFFF000, 1'b0);
    push(32'h800000EF, 32'hFFF00000, 1'b0);
    drain("b2b");

    // Backpressure: two accepted, third held off.
    out_ready = 1'b0;
    push(32'h00500113, 32'h00000005, 1'b0);
    push(32'h00A12023, 32'h00000000, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; instr_in = 32'h00700193;
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("bp");
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Flush when full with an offered word.
    out_ready = 1'b0;
    push(32'h00100093, 32'h00000001, 1'b0);
    push(32'h00200113, 32'h00000002, 1'b0);
    in_valid = 1'b1; instr_in = 32'h00300193; flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush_full");
    @(posedge clk); #1;

    // Flush at count 1 with a push that would otherwise be accepted.
    push(32'h00400213, 32'h00000004, 1'b0);
    in_valid = 1'b1; instr_in = 32'h00500293; flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush_one");
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("flushed_word_absent", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Unknown opcode.
    out_ready = 1'b1;
    push(32'h0000007F, 32'h00000000, 1'b1);
    push(32'hFFFFFF8B, 32'h00000000, 1'b1);
    push(32'h00000013, 32'h00000000, 1'b0);
    drain("illegal");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/instr_imm_stage.md
# instr_imm_stage

Registered instruction-decode buffer that accepts 32-bit instruction words from the fetch side, splits the RV64I fields and builds the raw 32-bit sign-correct immediate for the following 32→64 sign-extension stage. It holds up to two decoded entries behind a valid/ready handshake on both sides, so fetch and execute can stall independently. It sits between instruction memory/fetch and the sign extender / ALU operand mux.

## Interface
Parameters:
- DEPTH, 2, entry count; fixed at 2; other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  instr_in is valid this cycle
- in_ready  out  1  stage can accept a word; high when count < 2
- instr_in  in  32  raw instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry this cycle
- instr_out  out  32  head raw instruction
- opcode  out  7  head bits [6:0]
- rd  out  5  head bits [11:7]
- funct3  out  3  head bits [14:12]
- rs1  out  5  head bits [19:15]
- rs2  out  5  head bits [24:20]
- funct7  out  7  head bits [31:25]
- imm  out  32  head immediate, 32-bit two's-complement, fed to the sign extender
- illegal  out  1  head opcode not recognised (see Configuration)

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Decode happens at push; entries store instr, fields, imm, illegal. All outputs come from head-entry registers; no combinational path from instr_in to any output.
- Immediate by opcode (i = instr):
  - I (0000011, 0010011, 0011011, 1100111, 1110011): {20×i[31], i[31:20]}
  - S (0100011): {20×i[31], i[31:25], i[11:7]}
  - B (1100011): {19×i[31], i[31], i[7], i[30:25], i[11:8], 0}
  - U (0110111, 0010111): {i[31:12], 12'b0}
  - J (1101111): {11×i[31], i[31], i[19:12], i[20], i[30:21], 0}
  - R (0110011, 0111011): 0
  - any other opcode: imm = 0, illegal candidate.
- Storage: 2-entry circular buffer, 1-bit head/tail pointers wrapping 1→0, 2-bit count 0..2.
- count transitions: push only +1; pop only −1; push and pop same cycle unchanged (only legal when count = 1; at count 2 in_ready = 0, at count 0 out_valid = 0).
- out_valid = (count != 0); in_ready = (count != 2); both decoded from registered count.
- Priority: reset > flush > push/pop. Flush in same cycle as push drops the incoming word.

## Timing
- Reset (sync): count = 0, pointers = 0, stored entries cleared; next cycle out_valid = 0, in_ready = 1, instr_out/fields/imm/illegal = 0.
- Latency: word pushed at edge N appears on outputs with out_valid = 1 after edge N (cycle N+1); no bypass.
- Throughput: 1 word/cycle when out_ready held high.
- Full: after two pushes with no pop, in_ready = 0 next cycle; in_valid ignored while in_ready = 0.
- Outputs stable while out_valid && !out_ready.
- Flush or reset mid-stream: takes effect at that edge; next cycle empty, same values as after reset.

## Configuration
- IMMGEN_ILLEGAL_CHECK_EN defined: illegal = 1 for any opcode outside the listed I/S/B/U/J/R set, 0 otherwise; registered with the entry.
- Not defined: illegal tied to 0; unknown opcodes still give imm = 0; no illegal storage.

## Test plan
- Reset: assert reset 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, imm = 0 afterwards.
- Push 0xFFF00093 (addi x1,x0,−1), out_ready = 1 → next cycle opcode = 0x13, rd = 1, rs1 = 0, imm = 0xFFFFFFFF; out_valid low following cycle.
- Back-to-back 0xFE112E23 (sw), 0xFE000CE3 (beq), 0x123452B7 (lui), 0x001000EF (jal), out_ready = 1 → imm 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000, 0x00000800 on consecutive cycles.
- Backpressure: out_ready = 0, push three words → in_ready = 0 after second; third not accepted; release → first two drain in order, count returns to 0.
- Flush with count = 2 and in_valid = 1 → next cycle out_valid = 0, in_ready = 1; flushed word never appears.
- Push 0x0000007F → with IMMGEN_ILLEGAL_CHECK_EN illegal = 1, imm = 0; without macro illegal = 0, imm = 0.
